// File: rtl/devices_audio_mixer.sv
// devices_audio_mixer
// Time-multiplexed stereo mixer. A sample_tick snapshots all channel inputs,
// then one channel per clock is scaled by its left/right gain and summed into
// wide accumulators. A final cycle rescales, saturates and registers the
// stereo result alongside a valid strobe and clip flags.
//
// Handshake: sample_tick is a single-cycle request that is taken only while
// the FSM is idle (busy == 0). A tick seen while busy is dropped and reported
// on overrun for one cycle. valid is a one-cycle pulse and is not
// back-pressured; sound_L/sound_R and the clip flags hold until the next
// valid.
module devices_audio_mixer #(
  parameter int CHANNELS = 8,
  parameter int IN_W     = 16,
  parameter int OUT_W    = 16,
  parameter int GAIN_W   = 8,
  localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     sample_tick,
  input  logic [CHANNELS*IN_W-1:0] ch_in,
  input  logic [CHANNELS-1:0]      ch_en,
  input  logic                     cfg_we,
  input  logic [IDX_W-1:0]         cfg_ch,
  input  logic                     cfg_side,
  input  logic [GAIN_W-1:0]        cfg_gain,
  output logic [OUT_W-1:0]         sound_L,
  output logic [OUT_W-1:0]         sound_R,
  output logic                     valid,
  output logic                     busy,
  output logic                     clip_L,
  output logic                     clip_R,
  output logic                     overrun,
  output logic [1:0]               dbg_state
);

  // Accumulator holds CHANNELS products plus a sign bit, so it cannot wrap.
  localparam int ACC_W  = IN_W + GAIN_W + $clog2(CHANNELS) + 1;
  localparam int PROD_W = IN_W + GAIN_W + 1;
  // Rescaled value is widened past OUT_W so the overflow test always has
  // at least two bits above the output sign bit to compare.
  localparam int EXT_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CHANNELS - 1);
  localparam logic [GAIN_W-1:0] UNITY    = {1'b1, {(GAIN_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CHANNELS*IN_W-1:0] r_cap_in;
  logic [CHANNELS-1:0]      r_cap_en;
  logic [IDX_W-1:0]         r_idx;
  logic signed [ACC_W-1:0]  r_acc_l;
  logic signed [ACC_W-1:0]  r_acc_r;
  logic [GAIN_W-1:0]        r_gain_l [CHANNELS];
  logic [GAIN_W-1:0]        r_gain_r [CHANNELS];
  logic [OUT_W-1:0]         r_sound_l;
  logic [OUT_W-1:0]         r_sound_r;
  logic                     r_clip_l;
  logic                     r_clip_r;
  logic                     r_valid;
  logic                     r_overrun;

  logic                     w_start;
  logic                     w_drop;
  logic                     w_last;
  logic signed [IN_W-1:0]   w_sample;
  logic [GAIN_W-1:0]        w_gain_l;
  logic [GAIN_W-1:0]        w_gain_r;
  logic signed [PROD_W-1:0] w_prod_l;
  logic signed [PROD_W-1:0] w_prod_r;
  logic signed [EXT_W-1:0]  w_scaled_l;
  logic signed [EXT_W-1:0]  w_scaled_r;
  logic [OUT_W:0]           w_sat_l;
  logic [OUT_W:0]           w_sat_r;
  logic                     w_cfg_hit;

  // Returns {clipped, saturated value} for a rescaled accumulator.
  function automatic logic [OUT_W:0] saturate(input logic [EXT_W-1:0] v);
    logic [EXT_W-OUT_W:0] hi;
    hi = v[EXT_W-1:OUT_W-1];
    if ((&hi) || (~|hi)) begin
      saturate = {1'b0, v[OUT_W-1:0]};
    end else if (v[EXT_W-1]) begin
      saturate = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      saturate = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end
  endfunction

  // Current channel operands; gains are read before any same-cycle write lands.
  assign w_sample = $signed(r_cap_in[32'(r_idx) * IN_W +: IN_W]);
  assign w_gain_l = r_gain_l[r_idx];
  assign w_gain_r = r_gain_r[r_idx];
  assign w_prod_l = w_sample * $signed({1'b0, w_gain_l});
  assign w_prod_r = w_sample * $signed({1'b0, w_gain_r});

  // Arithmetic shift removes the unity-gain scale, rounding toward -inf.
  assign w_scaled_l = r_acc_l >>> (GAIN_W - 1);
  assign w_scaled_r = r_acc_r >>> (GAIN_W - 1);
  assign w_sat_l    = saturate(w_scaled_l);
  assign w_sat_r    = saturate(w_scaled_r);

  assign w_cfg_hit  = cfg_we && (32'(cfg_ch) < CHANNELS);

  // FSM state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and control decode.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_drop       = 1'b0;
    w_last       = (r_idx == LAST_IDX);
    case (r_state)
      ST_IDLE: begin
        if (sample_tick) begin
          w_start      = 1'b1;
          w_state_next = ST_MAC;
        end
      end
      ST_MAC: begin
        w_drop = sample_tick;
        if (w_last) begin
          w_state_next = ST_OUT;
        end
      end
      ST_OUT: begin
        w_drop       = sample_tick;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Snapshot, multiply-accumulate and output registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_cap_in  <= '0;
      r_cap_en  <= '0;
      r_idx     <= '0;
      r_acc_l   <= '0;
      r_acc_r   <= '0;
      r_sound_l <= '0;
      r_sound_r <= '0;
      r_clip_l  <= 1'b0;
      r_clip_r  <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= (r_state == ST_OUT);
      r_overrun <= w_drop;
      if (w_start) begin
        r_cap_in <= ch_in;
        r_cap_en <= ch_en;
        r_acc_l  <= '0;
        r_acc_r  <= '0;
        r_idx    <= '0;
      end
      if (r_state == ST_MAC) begin
        if (r_cap_en[r_idx]) begin
          r_acc_l <= r_acc_l + w_prod_l;
          r_acc_r <= r_acc_r + w_prod_r;
        end
        if (!w_last) begin
          r_idx <= r_idx + 1'b1;
        end
      end
      if (r_state == ST_OUT) begin
        r_sound_l <= w_sat_l[OUT_W-1:0];
        r_sound_r <= w_sat_r[OUT_W-1:0];
        r_clip_l  <= w_sat_l[OUT_W];
        r_clip_r  <= w_sat_r[OUT_W];
      end
    end
  end

  // Gain banks; writes land at any time, out-of-range channels are ignored.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_gain_l[i] <= UNITY;
        r_gain_r[i] <= UNITY;
      end
    end else if (w_cfg_hit) begin
      if (cfg_side) begin
        r_gain_r[cfg_ch] <= cfg_gain;
      end else begin
        r_gain_l[cfg_ch] <= cfg_gain;
      end
    end
  end

  assign sound_L   = r_sound_l;
  assign sound_R   = r_sound_r;
  assign clip_L    = r_clip_l;
  assign clip_R    = r_clip_r;
  assign valid     = r_valid;
  assign overrun   = r_overrun;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_devices_audio_mixer.sv
// Testbench for devices_audio_mixer (CHANNELS=8, 16-bit in/out, 8-bit gain).
module tb_devices_audio_mixer;

  localparam int CH = 8;
  localparam int IW = 16;
  localparam int OW = 16;
  localparam int GW = 8;

  // Clock / reset
  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  logic             sample_tick;
  logic [CH*IW-1:0] ch_in;
  logic [CH-1:0]    ch_en;
  logic             cfg_we;
  logic [2:0]       cfg_ch;
  logic             cfg_side;
  logic [GW-1:0]    cfg_gain;
  logic [OW-1:0]    sound_L;
  logic [OW-1:0]    sound_R;
  logic             valid;
  logic             busy;
  logic             clip_L;
  logic             clip_R;
  logic             overrun;
  logic [1:0]       dbg_state;

  devices_audio_mixer #(
    .CHANNELS(CH), .IN_W(IW), .OUT_W(OW), .GAIN_W(GW)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .sample_tick(sample_tick),
    .ch_in(ch_in), .ch_en(ch_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_side(cfg_side), .cfg_gain(cfg_gain), .sound_L(sound_L),
    .sound_R(sound_R), .valid(valid), .busy(busy), .clip_L(clip_L),
    .clip_R(clip_R), .overrun(overrun), .dbg_state(dbg_state)
  );

  // Scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: single gain write, applied on one rising edge.
  task automatic write_gain(input logic [2:0] ch, input logic side, input logic [GW-1:0] g);
    @(negedge clk_sys);
    cfg_we = 1'b1; cfg_ch = ch; cfg_side = side; cfg_gain = g;
    @(negedge clk_sys);
    cfg_we = 1'b0;
  endtask

  // Driver: one pass. Edge E samples the tick; iteration c observes the
  // outputs after edge E+c. wr_c/tick_c place a gain write or an extra
  // tick on edge E+c (0 = none). ch_after replaces ch_in right after E.
  task automatic run_pass(input string tag, input int wr_c, input logic [2:0] wch,
                          input logic wside, input logic [GW-1:0] wg, input int tick_c,
                          input logic [CH*IW-1:0] ch_after,
                          output int lat, output int n_valid, output int n_ovr);
    @(negedge clk_sys);
    sample_tick = 1'b1;
    @(negedge clk_sys);
    sample_tick = 1'b0;
    ch_in = ch_after;
    check({tag, "_busy_start"}, busy, 1);
    lat = -1; n_valid = 0; n_ovr = 0;
    for (int c = 1; c <= 20; c++) begin
      cfg_we = (c == wr_c); cfg_ch = wch; cfg_side = wside; cfg_gain = wg;
      sample_tick = (c == tick_c);
      @(negedge clk_sys);
      if (c == 8) check({tag, "_busy_mid"}, busy, 1);
      if (overrun) n_ovr++;
      if (valid) begin
        n_valid++;
        if (lat < 0) begin
          lat = c;
          check({tag, "_busy_at_valid"}, busy, 0);
        end
      end
    end
    cfg_we = 1'b0;
    sample_tick = 1'b0;
  endtask

  // Vector table: unity-gain passes with hand-computed results.
  typedef struct {
    logic [CH-1:0][IW-1:0] ch;
    logic [CH-1:0]         en;
    logic [OW-1:0]         exp_l;
    logic [OW-1:0]         exp_r;
    logic                  exp_cl;
    logic                  exp_cr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, nv, no;
    logic [CH-1:0][IW-1:0] w;

    reset = 1'b1; sample_tick = 1'b0; ch_in = '0; ch_en = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_side = 1'b0; cfg_gain = '0;

    for (int i = 0; i < 8; i++) begin
      vecs[i].ch = '0; vecs[i].en = '0;
      vecs[i].exp_cl = 1'b0; vecs[i].exp_cr = 1'b0;
    end
    // single channel, unity
    vecs[0].ch[0] = 16'h1234; vecs[0].en = 8'h01;
    vecs[0].exp_l = 16'h1234; vecs[0].exp_r = 16'h1234;
    // positive overflow: 0x7FFF + 0x7FFF
    vecs[1].ch[0] = 16'h7FFF; vecs[1].ch[1] = 16'h7FFF; vecs[1].en = 8'h03;
    vecs[1].exp_l = 16'h7FFF; vecs[1].exp_r = 16'h7FFF; vecs[1].exp_cl = 1; vecs[1].exp_cr = 1;
    // negative overflow: -32768 * 2
    vecs[2].ch[0] = 16'h8000; vecs[2].ch[1] = 16'h8000; vecs[2].en = 8'h03;
    vecs[2].exp_l = 16'h8000; vecs[2].exp_r = 16'h8000; vecs[2].exp_cl = 1; vecs[2].exp_cr = 1;
    // 100 - 50 + 200, ch3 (1000) muted -> 250
    vecs[3].ch[0] = 16'd100; vecs[3].ch[1] = 16'hFFCE; vecs[3].ch[2] = 16'd200;
    vecs[3].ch[3] = 16'd1000; vecs[3].en = 8'h07;
    vecs[3].exp_l = 16'h00FA; vecs[3].exp_r = 16'h00FA;
    // 8 x 0x1000 = 32768 -> clips by one
    for (int i = 0; i < 8; i++) vecs[4].ch[i] = 16'h1000;
    vecs[4].en = 8'hFF; vecs[4].exp_l = 16'h7FFF; vecs[4].exp_r = 16'h7FFF;
    vecs[4].exp_cl = 1; vecs[4].exp_cr = 1;
    // exactly full scale positive, no clip
    vecs[5].ch[6] = 16'h7000; vecs[5].ch[7] = 16'h0FFF; vecs[5].en = 8'hFF;
    vecs[5].exp_l = 16'h7FFF; vecs[5].exp_r = 16'h7FFF;
    // exactly full scale negative, last channel only
    vecs[6].ch[7] = 16'h8000; vecs[6].en = 8'h80;
    vecs[6].exp_l = 16'h8000; vecs[6].exp_r = 16'h8000;
    // all muted
    vecs[7].ch[0] = 16'h1234; vecs[7].ch[5] = 16'h4321; vecs[7].en = 8'h00;
    vecs[7].exp_l = 16'h0000; vecs[7].exp_r = 16'h0000;

    // Reset state
    repeat (2) @(negedge clk_sys);
    check("rst_sound_L", sound_L, 0);
    check("rst_sound_R", sound_R, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_clip_L", clip_L, 0);
    check("rst_clip_R", clip_R, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;

    // Table-driven passes
    for (int i = 0; i < 8; i++) begin
      ch_in = vecs[i].ch; ch_en = vecs[i].en;
      run_pass($sformatf("v%0d", i), 0, 3'd0, 1'b0, 8'h00, 0, vecs[i].ch, lat, nv, no);
      check($sformatf("v%0d_latency", i), lat, 9);
      check($sformatf("v%0d_nvalid", i), nv, 1);
      check($sformatf("v%0d_overrun", i), no, 0);
      check($sformatf("v%0d_sound_L", i), sound_L, vecs[i].exp_l);
      check($sformatf("v%0d_sound_R", i), sound_R, vecs[i].exp_r);
      check($sformatf("v%0d_clip_L", i), clip_L, vecs[i].exp_cl);
      check($sformatf("v%0d_clip_R", i), clip_R, vecs[i].exp_cr);
    end

    // Gain scaling with floor: -3 * 0x40 >>> 7 = -2, right side muted by gain 0
    write_gain(3'd2, 1'b0, 8'h40);
    write_gain(3'd2, 1'b1, 8'h00);
    w = '0; w[2] = 16'hFFFD; ch_in = w; ch_en = 8'h04;
    run_pass("gain", 0, 3'd0, 1'b0, 8'h00, 0, w, lat, nv, no);
    check("gain_sound_L", sound_L, 16'hFFFE);
    check("gain_sound_R", sound_R, 16'h0000);
    check("gain_clip_L", clip_L, 0);
    write_gain(3'd2, 1'b0, 8'h80);
    write_gain(3'd2, 1'b1, 8'h80);

    // Tick 4 cycles into a pass is dropped; first snapshot is used
    w = '0; w[0] = 16'h1234; ch_in = w; ch_en = 8'h01;
    w[0] = 16'h0100;
    run_pass("ovr", 0, 3'd0, 1'b0, 8'h00, 4, w, lat, nv, no);
    check("ovr_count", no, 1);
    check("ovr_nvalid", nv, 1);
    check("ovr_latency", lat, 9);
    check("ovr_sound_L", sound_L, 16'h1234);

    // Tick on the OUT edge is still dropped
    run_pass("ovr_out", 0, 3'd0, 1'b0, 8'h00, 9, w, lat, nv, no);
    check("ovr_out_count", no, 1);
    check("ovr_out_nvalid", nv, 1);
    check("ovr_out_sound_L", sound_L, 16'h0100);

    // Tick in the valid cycle starts a new pass, no overrun
    w[0] = 16'h0200;
    run_pass("b2b", 0, 3'd0, 1'b0, 8'h00, 10, w, lat, nv, no);
    check("b2b_overrun", no, 0);
    check("b2b_nvalid", nv, 2);
    check("b2b_sound_L", sound_L, 16'h0200);

    // Reset mid-pass: aborts, clears outputs, restores unity gain
    write_gain(3'd0, 1'b0, 8'h40);
    @(negedge clk_sys); sample_tick = 1'b1;
    @(negedge clk_sys); sample_tick = 1'b0;
    repeat (4) @(negedge clk_sys);
    reset = 1'b1;
    #1;
    check("midrst_sound_L", sound_L, 0);
    check("midrst_sound_R", sound_R, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", valid, 0);
    @(negedge clk_sys); reset = 1'b0;
    nv = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk_sys);
      if (valid) nv++;
    end
    check("midrst_no_valid", nv, 0);
    w = '0; w[0] = 16'h1234; ch_in = w; ch_en = 8'h01;
    run_pass("postrst", 0, 3'd0, 1'b0, 8'h00, 0, w, lat, nv, no);
    check("postrst_latency", lat, 9);
    check("postrst_sound_L", sound_L, 16'h1234);
    check("postrst_sound_R", sound_R, 16'h1234);

    // Same-cycle write to ch3 on its MAC edge (E+4): old gain used this pass
    w = '0; w[3] = 16'h0100; ch_in = w; ch_en = 8'h08;
    run_pass("samecyc", 4, 3'd3, 1'b0, 8'h00, 0, w, lat, nv, no);
    check("samecyc_sound_L", sound_L, 16'h0100);
    check("samecyc_sound_R", sound_R, 16'h0100);
    // New left gain applies; right write after ch3 was accumulated does not
    run_pass("next", 6, 3'd3, 1'b1, 8'h00, 0, w, lat, nv, no);
    check("next_sound_L", sound_L, 16'h0000);
    check("next_sound_R", sound_R, 16'h0100);
    run_pass("third", 0, 3'd0, 1'b0, 8'h00, 0, w, lat, nv, no);
    check("third_sound_R", sound_R, 16'h0000);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
